hsv_core_mem_issue: RTL
=======================

# hsv_core_mem_issue

Issue stage of the memory unit, directly upstream of `hsv_core_mem_response`. It accepts one decoded `read_write_t` request at a time and drives the data-memory AXI AR, AW and W channels. It tracks outstanding reads and writes, and the addresses of outstanding writes in order. Every request, including misaligned and fence requests that issue nothing on AXI, is forwarded to the response stage in program order.

## Interface
Parameters:
- `WRITE_FIFO_DEPTH`, default 8, power of two ≥2: capacity of the outstanding-write address FIFO.

Ports:
- `clk_core` in 1: core clock; all state on the rising edge.
- `rst_core` in 1: reset, synchronous, active-high.
- `flush` in 1: pipeline flush.
- `in` in `read_write_t`: request. Fields used: `address`, `misaligned_address`, `is_memory`, `mem_data.direction`, `mem_data.size`, `mem_data.fence`, and the store datum.
- `valid_i` in 1: `in` is valid.
- `ready_o` out 1: request accepted when `valid_i & ready_o`.
- `out` out `read_write_t`: request forwarded to the response stage.
- `valid_o` out 1: `out` is valid.
- `response_stall` in 1: response stage cannot take `out`.
- `fence_valid` out 1: a fence is held in `out`.
- `fence_ready` in 1: the response stage has retired the fence.
- `pending_reads_down` in 1: an R beat was consumed.
- `pending_writes_down` in 1: a B response was consumed.
- `pending_reads` out `mem_counter`: outstanding reads.
- `pending_writes` out `mem_counter`: outstanding writes.
- `pending_write_completed_address` out `word`: address of the oldest outstanding write (FIFO head).
- `dmem_ar_valid` out 1, `dmem_ar_ready` in 1, `dmem_ar_addr` out `word`: read address channel.
- `dmem_aw_valid` out 1, `dmem_aw_ready` in 1, `dmem_aw_addr` out `word`: write address channel.
- `dmem_w_valid` out 1, `dmem_w_ready` in 1, `dmem_w_data` out `word`, `dmem_w_strb` out 4: write data channel.

## Operation
- **State machine.** States are IDLE, ISSUE, HOLD and DRAIN. A request register `cur` holds the accepted request, with per-channel done flags `ar_done`, `aw_done`, `w_done`.
- **IDLE.**
  - `ready_o = ~flush & ~fence_block`.
  - On accept: load `cur` and clear the done flags.
  - If `cur` is misaligned or a fence, go to HOLD (no AXI activity). Otherwise go to ISSUE.
- **ISSUE, gating.** A channel valid rises only when no hazard exists. Once raised, it stays high until its handshake, even if a hazard later appears. Hazards:
  - read with `pending_reads` all-ones;
  - write with `pending_writes` all-ones, or with the FIFO full;
  - I/O request (`~is_memory`) while `pending_reads != 0` or `pending_writes != 0`;
  - memory read whose `address[31:2]` matches any valid FIFO entry (read-after-write ordering).
- **ISSUE, completion.** A read completes on the AR handshake. A write completes when both AW and W have handshaken; the two may complete in any order or together.
- **ISSUE, exit.** On completion go to HOLD. If `flush` was seen at any point during ISSUE, go to IDLE and drop the request instead.
- **HOLD.** Present `cur` on `out` with `valid_o = 1`. When `~response_stall`, drop `valid_o` and go to IDLE.
- **Fence blocking.** `fence_block` is set when a fence leaves HOLD. It clears on `fence_ready` or `flush`.
- **AXI payload.**
  - `ar_addr` and `aw_addr` are `{address[31:2], 2'b00}`.
  - `w_data` is the store datum shifted left by `8*address[1:0]`.
  - `w_strb`: byte → `4'b0001 << off`; half → `4'b0011 << off`; word → `4'b1111`.
- **Counters.**
  - `pending_reads`: +1 on the AR handshake, −1 on `pending_reads_down`, unchanged when both occur in the same cycle.
  - `pending_writes`: +1 in the cycle the write completes, −1 on `pending_writes_down`, unchanged when both occur.
  - The counters are not cleared by `flush`, because in-flight transactions still return.
- **Write FIFO.** Push `address` when a write completes; pop on `pending_writes_down`. A simultaneous push and pop is legal when full.
- **Flush.**
  - Clears `valid_o`, drops the request held in HOLD, and returns IDLE to IDLE.
  - In ISSUE, the state becomes DRAIN if any channel valid is already asserted or any done flag is set. DRAIN completes the remaining handshakes (counters and FIFO update normally), never sets `valid_o`, then goes to IDLE.
  - In ISSUE with no valid asserted and no done flag set, go straight to IDLE.

## Timing
- **Reset values:** state IDLE, `valid_o = 0`, all `dmem_*_valid = 0`, counters 0, FIFO empty, `fence_block = 0`, `ready_o = 1`.
- **Memory load latency:** accept at cycle N, `dmem_ar_valid = 1` at N+1. If `dmem_ar_ready` is high at N+1, `valid_o = 1` at N+2. Throughput is at most one request per 3 cycles.
- **Misaligned or fence request:** accept at N, `valid_o = 1` at N+1.
- **Output timing:** all AXI valids and `valid_o` come from registers. Hazard checks use current-cycle counter and FIFO values.

## Test plan
- **Load word:** `lw` to 0x100, `ar_ready = 1` → `ar_addr = 0x100` at N+1, `pending_reads = 1`, `valid_o` at N+2. Then `pending_reads_down` → `pending_reads = 0`.
- **Byte store:** `sb` of 0xAB to 0x203, `aw_ready` one cycle after `w_ready` → `w_data = 0xAB000000`, `w_strb = 4'b1000`, `aw_addr = 0x200`. `pending_writes = 1` only after both handshakes. `pending_write_completed_address = 0x203`.
- **Read-after-write hazard:** a write to 0x300 is outstanding, then `lw` 0x302 → AR held low until `pending_writes_down`. A load to 0x304 issues immediately.
- **Fence:** fence with `pending_writes = 2` → `fence_valid = 1` and no AXI activity. `ready_o` stays 0 after the handoff until `fence_ready`.
- **Flush during a write:** flush with `aw_done = 1` and W not yet done → W still completes and `pending_writes` increments. `valid_o` never rises. The next request is accepted afterwards.
- **Full FIFO:** fill the FIFO with `WRITE_FIFO_DEPTH` writes → the next write's AW and W stay low. A push and pop in the same cycle keeps the count unchanged.

Source files
------------

// File: rtl/hsv_core_mem_issue.sv
`default_nettype none
// ============================================================================
//  Module   : hsv_core_mem_issue (with hsv_core_mem_issue_pkg)
//  Brief    : Memory-unit issue stage. Takes one decoded request at a time,
//             drives the data-memory AXI AR/AW/W channels, tracks outstanding
//             reads/writes and the addresses of outstanding writes, and hands
//             every request to the response stage in program order.
//  Revision : 1.0 - initial release
// ============================================================================

package hsv_core_mem_issue_pkg;
    typedef logic [31:0] word;
    typedef logic [3:0]  mem_counter;

    localparam logic       c_dir_write = 1'b1;
    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;

    typedef struct packed {
        logic       direction;   // 1 = store
        logic [1:0] size;
        logic       fence;
    } mem_data_t;

    typedef struct packed {
        word       address;
        logic      misaligned_address;
        logic      is_memory;
        mem_data_t mem_data;
        word       write_data;
    } read_write_t;
endpackage

module hsv_core_mem_issue
    import hsv_core_mem_issue_pkg::*;
#(
    parameter int unsigned WRITE_FIFO_DEPTH = 8
) (
    input  logic        clk_core,
    input  logic        rst_core,
    input  logic        flush,
    input  read_write_t in,
    input  logic        valid_i,
    output logic        ready_o,
    output read_write_t out,
    output logic        valid_o,
    input  logic        response_stall,
    output logic        fence_valid,
    input  logic        fence_ready,
    input  logic        pending_reads_down,
    input  logic        pending_writes_down,
    output mem_counter  pending_reads,
    output mem_counter  pending_writes,
    output word         pending_write_completed_address,
    output logic        dmem_ar_valid,
    input  logic        dmem_ar_ready,
    output word         dmem_ar_addr,
    output logic        dmem_aw_valid,
    input  logic        dmem_aw_ready,
    output word         dmem_aw_addr,
    output logic        dmem_w_valid,
    input  logic        dmem_w_ready,
    output word         dmem_w_data,
    output logic [3:0]  dmem_w_strb
);
    localparam int unsigned        c_ptr_w   = $clog2(WRITE_FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(WRITE_FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam mem_counter         c_pc_one  = mem_counter'(1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [1:0]            r_state;
    read_write_t           r_cur;
    logic                  r_ar_valid, r_aw_valid, r_w_valid;
    logic                  r_ar_done, r_aw_done, r_w_done;
    logic                  r_valid_o;
    logic                  r_fence_block;
    mem_counter            r_pending_reads, r_pending_writes;
    word                   r_fifo_addr [WRITE_FIFO_DEPTH];
    logic [WRITE_FIFO_DEPTH-1:0] r_fifo_vld;
    logic [c_ptr_w-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_ptr_w:0]      r_count;

    logic        w_ar_hs, w_aw_hs, w_w_hs;
    logic        w_active, w_accept, w_in_write, w_cur_write, w_bypass_in;
    logic        w_rd_done_now, w_wr_done_now, w_complete, w_pop, w_fifo_full;
    logic [29:0] w_hz_line;
    logic        w_hz_is_mem, w_raw, w_io_hz, w_rd_hz, w_wr_hz;
    logic [1:0]  w_off;

    assign w_ar_hs     = r_ar_valid & dmem_ar_ready;
    assign w_aw_hs     = r_aw_valid & dmem_aw_ready;
    assign w_w_hs      = r_w_valid  & dmem_w_ready;
    assign w_active    = (r_state == c_st_issue) | (r_state == c_st_drain);
    assign ready_o     = (r_state == c_st_idle) & ~flush & ~r_fence_block;
    assign w_accept    = valid_i & ready_o;
    assign w_in_write  = (in.mem_data.direction == c_dir_write);
    assign w_cur_write = (r_cur.mem_data.direction == c_dir_write);
    assign w_bypass_in = in.misaligned_address | in.mem_data.fence;

    // A store is finished once both AW and W have handshaken, in either order
    assign w_rd_done_now = w_active & ~w_cur_write & w_ar_hs;
    assign w_wr_done_now = w_active & w_cur_write & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);
    assign w_complete    = w_rd_done_now | w_wr_done_now;
    assign w_pop         = pending_writes_down & (r_count != '0);
    assign w_fifo_full   = (r_count == c_depth);

    // Hazards are evaluated on the incoming request while idle so a clean
    // request can raise its channel valid on the accept edge itself
    always_comb begin
        w_hz_line   = (r_state == c_st_idle) ? in.address[31:2] : r_cur.address[31:2];
        w_hz_is_mem = (r_state == c_st_idle) ? in.is_memory     : r_cur.is_memory;
        w_raw       = 1'b0;
        for (int i = 0; i < WRITE_FIFO_DEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_addr[i][31:2] == w_hz_line)) w_raw = 1'b1;
        end
        w_io_hz = ~w_hz_is_mem & ((r_pending_reads != '0) | (r_pending_writes != '0));
        w_rd_hz = (&r_pending_reads) | w_io_hz | (w_hz_is_mem & w_raw);
        w_wr_hz = (&r_pending_writes) | w_fifo_full | w_io_hz;
    end

    // Request FSM: accept, issue AXI channels, hand off, or drain after flush
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state    <= c_st_idle;
            r_cur      <= '0;
            r_ar_valid <= 1'b0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_done  <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_valid_o  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_cur     <= in;
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        if (w_bypass_in) begin
                            r_state   <= c_st_hold;
                            r_valid_o <= 1'b1;
                        end else begin
                            r_state    <= c_st_issue;
                            r_ar_valid <= ~w_in_write & ~w_rd_hz;
                            r_aw_valid <= w_in_write & ~w_wr_hz;
                            r_w_valid  <= w_in_write & ~w_wr_hz;
                        end
                    end
                end
                c_st_issue, c_st_drain: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        r_ar_done  <= 1'b1;
                    end else if (~r_ar_valid & ~r_ar_done & ~w_cur_write & ~w_rd_hz) begin
                        r_ar_valid <= 1'b1;
                    end
                    if (w_aw_hs) begin
                        r_aw_valid <= 1'b0;
                        r_aw_done  <= 1'b1;
                    end else if (~r_aw_valid & ~r_aw_done & w_cur_write & ~w_wr_hz) begin
                        r_aw_valid <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_valid <= 1'b0;
                        r_w_done  <= 1'b1;
                    end else if (~r_w_valid & ~r_w_done & w_cur_write & ~w_wr_hz) begin
                        r_w_valid <= 1'b1;
                    end
                    if (w_complete) begin
                        if ((r_state == c_st_issue) && !flush) begin
                            r_state   <= c_st_hold;
                            r_valid_o <= 1'b1;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else if ((r_state == c_st_issue) && flush) begin
                        // Anything already on the bus must still finish
                        if (r_ar_valid | r_aw_valid | r_w_valid | r_ar_done | r_aw_done | r_w_done) begin
                            r_state <= c_st_drain;
                        end else begin
                            r_state    <= c_st_idle;
                            r_ar_valid <= 1'b0;
                            r_aw_valid <= 1'b0;
                            r_w_valid  <= 1'b0;
                        end
                    end
                end
                c_st_hold: begin
                    if (flush | ~response_stall) begin
                        r_valid_o <= 1'b0;
                        r_state   <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Fence blocks new requests from handoff until the response stage retires it
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_fence_block <= 1'b0;
        end else if (flush | fence_ready) begin
            r_fence_block <= 1'b0;
        end else if ((r_state == c_st_hold) & ~response_stall & r_cur.mem_data.fence) begin
            r_fence_block <= 1'b1;
        end
    end

    // Outstanding counters survive flush since in-flight transactions still return
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_pending_reads  <= '0;
            r_pending_writes <= '0;
        end else begin
            case ({w_ar_hs, pending_reads_down})
                2'b10:   r_pending_reads <= r_pending_reads + c_pc_one;
                2'b01:   r_pending_reads <= r_pending_reads - c_pc_one;
                default: r_pending_reads <= r_pending_reads;
            endcase
            case ({w_wr_done_now, pending_writes_down})
                2'b10:   r_pending_writes <= r_pending_writes + c_pc_one;
                2'b01:   r_pending_writes <= r_pending_writes - c_pc_one;
                default: r_pending_writes <= r_pending_writes;
            endcase
        end
    end

    // Outstanding-write FIFO control; push follows pop so a full push+pop reuses the slot
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fifo_vld <= '0;
        end else begin
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= r_rd_ptr + c_ptr_one;
            end
            if (w_wr_done_now) begin
                r_fifo_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr             <= r_wr_ptr + c_ptr_one;
            end
            case ({w_wr_done_now, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Outstanding-write address storage (no reset needed, qualified by r_fifo_vld)
    always_ff @(posedge clk_core) begin
        if (w_wr_done_now) r_fifo_addr[r_wr_ptr] <= r_cur.address;
    end

    // Store lane placement from the low address bits
    always_comb begin
        w_off = r_cur.address[1:0];
        case (r_cur.mem_data.size)
            c_size_byte: dmem_w_strb = 4'b0001 << w_off;
            c_size_half: dmem_w_strb = 4'b0011 << w_off;
            c_size_word: dmem_w_strb = 4'b1111;
            default:     dmem_w_strb = 4'b1111;
        endcase
    end

    assign dmem_w_data    = r_cur.write_data << {w_off, 3'b000};
    assign dmem_ar_addr   = {r_cur.address[31:2], 2'b00};
    assign dmem_aw_addr   = {r_cur.address[31:2], 2'b00};
    assign dmem_ar_valid  = r_ar_valid;
    assign dmem_aw_valid  = r_aw_valid;
    assign dmem_w_valid   = r_w_valid;
    assign out            = r_cur;
    assign valid_o        = r_valid_o;
    assign fence_valid    = r_valid_o & r_cur.mem_data.fence;
    assign pending_reads  = r_pending_reads;
    assign pending_writes = r_pending_writes;
    assign pending_write_completed_address = r_fifo_addr[r_rd_ptr];

endmodule
`default_nettype wire
